// File: rtl/jacobi_pkg.sv
// Types shared by the Jacobi main controller and the rotation result buffer.
package jacobi_pkg;

    localparam int DEF_OUT_WORD_WIDTH = 20;

    typedef struct packed {
        logic [DEF_OUT_WORD_WIDTH-1:0] x;
        logic [DEF_OUT_WORD_WIDTH-1:0] y;
        logic [DEF_OUT_WORD_WIDTH-1:0] z;
    } rot_triplet_t;

endpackage

// File: rtl/jacobi_rotation_fifo.sv
// In-order result buffer behind the non-stallable rotation CORDIC.
// Issues are admitted only when a buffer slot is reserved for their result.
module jacobi_rotation_fifo
    import jacobi_pkg::*;
#(
    parameter int OUT_WORD_WIDTH = DEF_OUT_WORD_WIDTH,
    parameter int DEPTH          = 16,
    localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_i,
    output logic                      issue_ok_o,
    input  logic [OUT_WORD_WIDTH-1:0] in_dat_x_i,
    input  logic [OUT_WORD_WIDTH-1:0] in_dat_y_i,
    input  logic [OUT_WORD_WIDTH-1:0] in_dat_z_i,
    input  logic                      in_vld_i,
    output logic [OUT_WORD_WIDTH-1:0] out_dat_x_o,
    output logic [OUT_WORD_WIDTH-1:0] out_dat_y_o,
    output logic [OUT_WORD_WIDTH-1:0] out_dat_z_o,
    output logic                      out_vld_o,
    input  logic                      out_rdy_i,
    output logic [ADDR_WIDTH:0]       count_o,
    output logic                      err_o
);

    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ZERO_LVL = (ADDR_WIDTH+1)'(0);

    rot_triplet_t              mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0]     wr_ptr_r;
    logic [ADDR_WIDTH-1:0]     rd_ptr_r;
    logic [ADDR_WIDTH:0]       count_r;
    logic [ADDR_WIDTH:0]       reserved_r;
    logic                      err_r;

    logic                      pop_s;
    logic                      push_s;
    logic                      issue_acc_s;
    logic                      unres_push_s;
    logic                      err_hit_s;
    logic [ADDR_WIDTH:0]       count_nxt_s;
    logic [ADDR_WIDTH:0]       reserved_nxt_s;

    assign issue_ok_o  = (reserved_r < FULL_LVL);
    assign out_vld_o   = (count_r != ZERO_LVL);
    assign out_dat_x_o = mem_r[rd_ptr_r].x;
    assign out_dat_y_o = mem_r[rd_ptr_r].y;
    assign out_dat_z_o = mem_r[rd_ptr_r].z;
    assign count_o     = count_r;
    assign err_o       = err_r;

    // Handshake decode, protocol error detection and next counter values.
    always_comb begin
        pop_s        = out_vld_o && out_rdy_i;
        push_s       = in_vld_i && ((count_r < FULL_LVL) || pop_s);
        issue_acc_s  = issue_i && issue_ok_o;
        unres_push_s = push_s && (reserved_r == count_r);
        err_hit_s    = (issue_i && !issue_ok_o)
                     || (in_vld_i && (count_r == FULL_LVL) && !pop_s)
                     || (in_vld_i && (reserved_r == count_r));

        if (push_s && !pop_s) begin
            count_nxt_s = count_r + (ADDR_WIDTH+1)'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - (ADDR_WIDTH+1)'(1);
        end else begin
            count_nxt_s = count_r;
        end

        // An unsolicited result that was stored also claims a reservation,
        // so reserved never drops below count and cannot wrap on its pop.
        reserved_nxt_s = reserved_r
                       + (ADDR_WIDTH+1)'(issue_acc_s)
                       + (ADDR_WIDTH+1)'(unres_push_s)
                       - (ADDR_WIDTH+1)'(pop_s);
    end

    // Pointer, counter and sticky error state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= ADDR_WIDTH'(0);
            rd_ptr_r   <= ADDR_WIDTH'(0);
            count_r    <= ZERO_LVL;
            reserved_r <= ZERO_LVL;
            err_r      <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
            end
            count_r    <= count_nxt_s;
            reserved_r <= reserved_nxt_s;
            err_r      <= err_r | err_hit_s;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= '{x: in_dat_x_i, y: in_dat_y_i, z: in_dat_z_i};
        end
    end

endmodule
